// File: rtl/target_frame_uart_tx.sv
// 8N1 UART transmitter for the selected target byte: sends on change, and
// periodically re-sends the last byte so late-joining receivers resynchronise.
module target_frame_uart_tx #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int BAUD          = 9600,
  parameter int RESEND_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] target_data,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] last_sent
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int RESEND_W     = (RESEND_CYCLES > 0) ? $clog2(RESEND_CYCLES + 1) : 1;

  localparam logic [BAUD_W-1:0]   BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [RESEND_W-1:0] RESEND_LAST = RESEND_W'((RESEND_CYCLES > 0) ? RESEND_CYCLES - 1 : 0);
  localparam logic                RESEND_EN   = (RESEND_CYCLES != 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]          state_reg, state_next;
  logic [BAUD_W-1:0]   baud_cnt_reg, baud_cnt_next;
  logic [2:0]          bit_cnt_reg, bit_cnt_next;
  logic [RESEND_W-1:0] resend_cnt_reg, resend_cnt_next;
  logic [7:0]          shadow_reg, shadow_next;
  logic [7:0]          last_sent_reg, last_sent_next;
  logic                tx_reg, tx_next;

  logic [7:0] new_byte;
  logic       change_trig;
  logic       resend_trig;
  logic       baud_done;
  logic       unused_reserved;

  assign new_byte        = target_data[7:0];
  assign unused_reserved = target_data[8];

  assign change_trig = (new_byte != last_sent_reg) && (new_byte != 8'd0);
  assign resend_trig = RESEND_EN && (last_sent_reg != 8'd0) && (resend_cnt_reg == RESEND_LAST);
  assign baud_done   = (baud_cnt_reg == BAUD_LAST);

  always_comb begin
    state_next      = state_reg;
    baud_cnt_next   = baud_cnt_reg;
    bit_cnt_next    = bit_cnt_reg;
    resend_cnt_next = '0;
    shadow_next     = shadow_reg;
    last_sent_next  = last_sent_reg;

    case (state_reg)
      S_IDLE: begin
        baud_cnt_next = '0;
        bit_cnt_next  = '0;
        // A fresh value takes priority over a coincident periodic resend.
        if (change_trig) begin
          shadow_next    = new_byte;
          last_sent_next = new_byte;
          state_next     = S_START;
        end else if (resend_trig) begin
          shadow_next = last_sent_reg;
          state_next  = S_START;
        end else if (RESEND_EN && (last_sent_reg != 8'd0)) begin
          resend_cnt_next = resend_cnt_reg + RESEND_W'(1);
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = S_DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          if (bit_cnt_reg == 3'd7) begin
            state_next = S_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          state_next    = S_GAP;
        end else begin
          baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
        end
      end
      S_GAP: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          state_next    = S_IDLE;
        end else begin
          baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
        end
      end
      default: begin
        state_next    = S_IDLE;
        baud_cnt_next = '0;
        bit_cnt_next  = '0;
      end
    endcase
  end

  // Line level is derived from the next state so tx itself is a flop.
  always_comb begin
    tx_next = 1'b1;
    if (state_next == S_START) begin
      tx_next = 1'b0;
    end else if (state_next == S_DATA) begin
      tx_next = shadow_next[bit_cnt_next];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      baud_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      resend_cnt_reg <= '0;
      shadow_reg     <= '0;
      last_sent_reg  <= '0;
      tx_reg         <= 1'b1;
    end else begin
      state_reg      <= state_next;
      baud_cnt_reg   <= baud_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      resend_cnt_reg <= resend_cnt_next;
      shadow_reg     <= shadow_next;
      last_sent_reg  <= last_sent_next;
      tx_reg         <= tx_next;
    end
  end

  assign tx         = tx_reg;
  assign busy       = (state_reg != S_IDLE);
  assign frame_done = (state_reg == S_STOP) && baud_done;
  assign last_sent  = last_sent_reg;

endmodule
